// File: rtl/pl_stage_seq_if.sv
// SHAKE core sharing bus: packed client-side buses in, one core-side bus out.
// The sequencer takes the master view; clients and the core together take the slave view.
interface pl_stage_seq_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int SHAKE_W     = 32
);
  logic [NUM_CLIENTS*SHAKE_W-1:0] c_shake_in;
  logic [NUM_CLIENTS-1:0]         c_shake_in_ready;
  logic [NUM_CLIENTS-1:0]         c_shake_is_last;
  logic [NUM_CLIENTS-1:0]         c_shake_squeeze;
  logic [NUM_CLIENTS-1:0]         c_shake_rst;
  logic [NUM_CLIENTS*2-1:0]       c_shake_byte_num;
  logic [NUM_CLIENTS-1:0]         c_shake_out_ready;

  logic [SHAKE_W-1:0]             shake_in;
  logic                           shake_in_ready;
  logic                           shake_is_last;
  logic                           shake_squeeze;
  logic                           shake_rst;
  logic [1:0]                     shake_byte_num;
  logic                           shake_out_ready;

  modport master (
    input  c_shake_in, c_shake_in_ready, c_shake_is_last, c_shake_squeeze,
           c_shake_rst, c_shake_byte_num, shake_out_ready,
    output c_shake_out_ready, shake_in, shake_in_ready, shake_is_last,
           shake_squeeze, shake_rst, shake_byte_num
  );

  modport slave (
    output c_shake_in, c_shake_in_ready, c_shake_is_last, c_shake_squeeze,
           c_shake_rst, c_shake_byte_num, shake_out_ready,
    input  c_shake_out_ready, shake_in, shake_in_ready, shake_is_last,
           shake_squeeze, shake_rst, shake_byte_num
  );
endinterface

// File: rtl/pl_stage_seq.sv
// Multi-phase stage sequencer: pulses per-phase unit starts, waits on dones,
// and grants the shared SHAKE core to one client per phase, with watchdog and abort.
module pl_stage_seq #(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_CLIENTS = 2,
  parameter int NUM_PHASES  = 2,
  parameter int SHAKE_W     = 32,
  parameter logic [NUM_PHASES*NUM_UNITS-1:0] START_MASK = {4'b1110, 4'b0001},
  parameter logic [NUM_PHASES*NUM_UNITS-1:0] WAIT_MASK  = {4'b0010, 4'b0001},
  parameter logic [NUM_PHASES*4-1:0]         OWNER      = {4'd1, 4'd0},
  parameter int TIMEOUT     = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start_stage,
  input  logic                 abort,
  output logic                 done_stage,
  output logic                 error,
  output logic                 busy,
  output logic [3:0]           phase,
  output logic [NUM_UNITS-1:0] start_units,
  input  logic [NUM_UNITS-1:0] done_units,
  pl_stage_seq_if.master       shk
);

  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t               state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic [NUM_UNITS-1:0] done_seen_q, done_seen_d;
  logic [NUM_UNITS-1:0] start_units_q, start_units_d;
  logic                 done_stage_q, done_stage_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;

  logic [NUM_UNITS-1:0] wmask;
  logic                 complete;
  logic                 wdog_expired;
  logic [3:0]           owner;
  logic                 sel_rst;

  function automatic logic [NUM_UNITS-1:0] start_mask_f(input logic [3:0] p);
    logic [NUM_UNITS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (p == 4'(i)) m = START_MASK[i*NUM_UNITS +: NUM_UNITS];
    end
    return m;
  endfunction

  function automatic logic [NUM_UNITS-1:0] wait_mask_f(input logic [3:0] p);
    logic [NUM_UNITS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (p == 4'(i)) m = WAIT_MASK[i*NUM_UNITS +: NUM_UNITS];
    end
    return m;
  endfunction

  // Out-of-range owner indices fall back to client 0.
  function automatic logic [3:0] owner_f(input logic [3:0] p);
    logic [3:0] o;
    o = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (p == 4'(i)) o = OWNER[i*4 +: 4];
    end
    if (int'(o) >= NUM_CLIENTS) o = '0;
    return o;
  endfunction

  assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDOG_W'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wdog_d       = wdog_q;
    done_seen_d  = done_seen_q | done_units;
    done_stage_d = 1'b0;
    error_d      = 1'b0;
    wmask        = wait_mask_f(phase_q);
    complete     = ((done_seen_q | done_units) & wmask) == wmask;

    if (en) begin
      if (abort && (state_q != IDLE)) begin
        state_d = IDLE;
        phase_d = '0;
        error_d = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_stage) begin
              state_d = LAUNCH;
              phase_d = '0;
            end
          end
          LAUNCH: begin
            // Forget dones from the previous phase but keep any arriving now.
            done_seen_d = done_units;
            wdog_d      = '0;
            state_d     = WAIT;
          end
          WAIT: begin
            wdog_d = wdog_q + 1'b1;
            if (complete) begin
              if (phase_q == 4'(NUM_PHASES - 1)) begin
                state_d = FINISH;
              end else begin
                phase_d = phase_q + 4'd1;
                state_d = LAUNCH;
              end
            end else if (wdog_expired) begin
              state_d = IDLE;
              phase_d = '0;
              error_d = 1'b1;
            end
          end
          FINISH: begin
            done_stage_d = 1'b1;
            phase_d      = '0;
            state_d      = IDLE;
          end
          default: begin
            state_d = IDLE;
            phase_d = '0;
          end
        endcase
      end
    end

    // Start pulse is registered on LAUNCH entry so it coincides with the LAUNCH cycle.
    start_units_d = ((state_q != LAUNCH) && (state_d == LAUNCH)) ? start_mask_f(phase_d) : '0;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      wdog_q        <= '0;
      done_seen_q   <= '0;
      start_units_q <= '0;
      done_stage_q  <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      wdog_q        <= wdog_d;
      done_seen_q   <= done_seen_d;
      start_units_q <= start_units_d;
      done_stage_q  <= done_stage_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  assign done_stage  = done_stage_q;
  assign error       = error_q;
  assign busy        = busy_q;
  assign phase       = phase_q;
  assign start_units = start_units_q;

  // SHAKE mux follows the registered phase, so a new owner takes over from its LAUNCH cycle.
  always_comb begin
    owner                 = (state_q == IDLE) ? 4'd0 : owner_f(phase_q);
    shk.shake_in          = '0;
    shk.shake_in_ready    = 1'b0;
    shk.shake_is_last     = 1'b0;
    shk.shake_squeeze     = 1'b0;
    shk.shake_byte_num    = '0;
    shk.c_shake_out_ready = '0;
    sel_rst               = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (owner == 4'(i)) begin
        shk.shake_in          = shk.c_shake_in[i*SHAKE_W +: SHAKE_W];
        shk.shake_in_ready    = shk.c_shake_in_ready[i];
        shk.shake_is_last     = shk.c_shake_is_last[i];
        shk.shake_squeeze     = shk.c_shake_squeeze[i];
        shk.shake_byte_num    = shk.c_shake_byte_num[i*2 +: 2];
        sel_rst               = shk.c_shake_rst[i];
        shk.c_shake_out_ready[i] = shk.shake_out_ready;
      end
    end
    shk.shake_rst = sel_rst | rst;
  end

endmodule
